// File: rtl/m_seq_chk_pkg.sv
// Shared definitions for the 6-bit m-sequence checker: default tap
// polynomial, checker state encoding and the next-bit predictor.
package m_seq_chk_pkg;

    // Feedback taps; same encoding as the m-sequence generator.
    localparam logic [5:0] POLY_DEF = 6'b101101;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // hist[0] is the oldest bit (n-6), hist[5] the newest (n-1).
    // Tap poly[5-k] selects hist[k].
    function automatic logic pred(
        input logic [5:0] hist,
        input logic [5:0] poly
    );
        logic r;
        r = 1'b0;
        for (int k = 0; k < 6; k++) begin
            r = r ^ (poly[5-k] & hist[k]);
        end
        return r;
    endfunction

endpackage

// File: rtl/m_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
// Ports: clk, rst (sync, active-high), clr, inc -> cnt (sticks at all-ones).
module m_seq_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            // Clear wins over a same-cycle increment.
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/m_seq_chk.sv
// Receive-side checker for the 6-bit m-sequence: self-syncs, flywheels
// once locked, counts errors/bits, drops lock on dense errors.
// Ports: sclk, rst (sync, active-high), din, din_valid, clr (counter clear)
//        -> locked, err_pulse, err_cnt, bit_cnt, status (history register).
module m_seq_chk
    import m_seq_chk_pkg::*;
#(
    parameter logic [5:0] POLY    = POLY_DEF,
    parameter int         SYNC_N  = 12,
    parameter int         WIN     = 63,
    parameter int         LOSS_TH = 8,
    parameter int         CNT_W   = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [5:0]       status
);

    localparam int MW = $clog2(SYNC_N + 1);
    localparam int WW = $clog2(WIN);
    localparam int EW = $clog2(LOSS_TH + 1);

    state_t          state, state_n;
    logic [5:0]      hist, hist_n;
    logic [2:0]      fill_cnt, fill_cnt_n;
    logic [MW-1:0]   match_cnt, match_cnt_n;
    logic [WW-1:0]   win_cnt, win_cnt_n;
    logic [EW-1:0]   win_err, win_err_n;
    logic [EW-1:0]   werr_sum;
    logic            pulse_n;
    logic            err_inc;
    logic            bit_inc;
    logic            p;
    logic            mis;

    assign p      = pred(hist, POLY);
    assign mis    = din ^ p;
    assign status = hist;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            locked    <= (state_n == LOCK);
            err_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_cnt_n  = fill_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        pulse_n     = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;
        // Window error count saturates at the loss threshold.
        werr_sum    = (mis && (win_err != EW'(LOSS_TH)))
                      ? win_err + 1'b1 : win_err;

        if (din_valid) begin
            unique case (state)
                FILL: begin
                    hist_n = {din, hist[5:1]};
                    if (fill_cnt == 3'd5) begin
                        state_n    = SEARCH;
                        fill_cnt_n = '0;
                    end else begin
                        fill_cnt_n = fill_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    hist_n = {din, hist[5:1]};
                    // An all-zero history predicts zero forever; never
                    // let it count toward lock.
                    if (!mis && (hist != 6'd0)) begin
                        if (match_cnt == MW'(SYNC_N - 1)) begin
                            state_n     = LOCK;
                            match_cnt_n = '0;
                            win_cnt_n   = '0;
                            win_err_n   = '0;
                        end else begin
                            match_cnt_n = match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt_n = '0;
                    end
                end
                LOCK: begin
                    // Flywheel on our own prediction.
                    hist_n  = {p, hist[5:1]};
                    bit_inc = 1'b1;
                    if (mis) begin
                        pulse_n = 1'b1;
                        err_inc = 1'b1;
                    end
                    if (win_cnt == WW'(WIN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                        if (werr_sum >= EW'(LOSS_TH)) begin
                            state_n     = FILL;
                            fill_cnt_n  = '0;
                            match_cnt_n = '0;
                        end
                    end else begin
                        win_cnt_n = win_cnt + 1'b1;
                        win_err_n = werr_sum;
                    end
                end
                default: begin
                    state_n = FILL;
                end
            endcase
        end
    end

    m_seq_sat_cnt #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (sclk),
        .rst (rst),
        .clr (clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    m_seq_sat_cnt #(
        .W (CNT_W)
    ) u_bit_cnt (
        .clk (sclk),
        .rst (rst),
        .clr (clr),
        .inc (bit_inc),
        .cnt (bit_cnt)
    );

endmodule
